// File: rtl/ctrl_sequencer.sv
// Instruction sequencer for the 8-bit accumulator processor: fetch/decode/execute
// FSM that turns program-memory words into one-cycle datapath control strobes.
module ctrl_sequencer (
  input  logic       clk,
  input  logic       rstn_inter,
  input  logic [7:0] prog_mem_data,
  input  logic       zero_flag,
  output logic       pc_inc,
  output logic       cnt_load,
  output logic [4:0] cnt_val,
  output logic       load_en,
  output logic       store_en,
  output logic       R0_ce,
  output logic       R1_ce,
  output logic       R0_oe,
  output logic       R1_oe,
  output logic       alu_en,
  output logic [2:0] alu_op,
  output logic       imm_en,
  output logic [7:0] imm_val,
  output logic       halted,
  output logic [2:0] state_dbg
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_LD   = 3'd1;
  localparam logic [OP_W-1:0] OP_ST   = 3'd2;
  localparam logic [OP_W-1:0] OP_ALU  = 3'd3;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd4;
  localparam logic [OP_W-1:0] OP_JZ   = 3'd5;
  localparam logic [OP_W-1:0] OP_LDI  = 3'd6;
  localparam logic [OP_W-1:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = ir_q[7:5];
  assign operand = ir_q[4:0];

  // State and instruction register; ir only loads in FETCH
  always_ff @(posedge clk or negedge rstn_inter) begin
    if (!rstn_inter) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= prog_mem_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_ALU)       state_d = S_WB;
        else if (opcode == OP_HALT) state_d = S_HALT;
        else                        state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes decode from registered state/ir, so async reset clears them at once
  always_comb begin
    pc_inc    = 1'b0;
    cnt_load  = 1'b0;
    load_en   = 1'b0;
    store_en  = 1'b0;
    R0_ce     = 1'b0;
    R1_ce     = 1'b0;
    R0_oe     = 1'b0;
    R1_oe     = 1'b0;
    alu_en    = 1'b0;
    alu_op    = '0;
    imm_en    = 1'b0;
    cnt_val   = operand;
    imm_val   = DATA_W'({3'b000, operand});
    halted    = (state_q == S_HALT);
    state_dbg = state_q;
    if (state_q == S_EXEC) begin
      unique case (opcode)
        OP_NOP: pc_inc = 1'b1;
        OP_LD: begin
          R0_oe   = ~ir_q[0];
          R1_oe   = ir_q[0];
          load_en = 1'b1;
          pc_inc  = 1'b1;
        end
        OP_ST: begin
          store_en = 1'b1;
          R0_ce    = ~ir_q[0];
          R1_ce    = ir_q[0];
          pc_inc   = 1'b1;
        end
        OP_ALU: begin
          alu_en = 1'b1;
          alu_op = ir_q[2:0];
          R1_oe  = 1'b1;
        end
        OP_JMP: cnt_load = 1'b1;
        OP_JZ: begin
          cnt_load = zero_flag;
          pc_inc   = ~zero_flag;
        end
        OP_LDI: begin
          imm_en  = 1'b1;
          load_en = 1'b1;
          pc_inc  = 1'b1;
        end
        OP_HALT: ;
        default: ;
      endcase
    end else if (state_q == S_WB) begin
      load_en = 1'b1;
      alu_en  = 1'b1;
      alu_op  = ir_q[2:0];
      R1_oe   = 1'b1;
      pc_inc  = 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: program-memory + PC model around the DUT, with a
// scoreboard of expected EXEC/WB strobe patterns checked by a separate monitor.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rstn_inter;
  logic [7:0] prog_mem_data;
  logic       zero_flag;
  logic       pc_inc, cnt_load, load_en, store_en;
  logic       R0_ce, R1_ce, R0_oe, R1_oe, alu_en, imm_en, halted;
  logic [4:0] cnt_val;
  logic [2:0] alu_op, state_dbg;
  logic [7:0] imm_val;

  logic [7:0] mem [32];
  logic [4:0] pc;

  int errors = 0;
  int checks = 0;

  // Strobe vector bit order: pc_inc,cnt_load,load_en,store_en,R0_ce,R1_ce,R0_oe,R1_oe,alu_en,imm_en
  localparam logic [9:0] PI = 10'b1000000000;
  localparam logic [9:0] CL = 10'b0100000000;
  localparam logic [9:0] LE = 10'b0010000000;
  localparam logic [9:0] SE = 10'b0001000000;
  localparam logic [9:0] C0 = 10'b0000100000;
  localparam logic [9:0] C1 = 10'b0000010000;
  localparam logic [9:0] O0 = 10'b0000001000;
  localparam logic [9:0] O1 = 10'b0000000100;
  localparam logic [9:0] AE = 10'b0000000010;
  localparam logic [9:0] IE = 10'b0000000001;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] sb;
    logic [2:0] op;
    logic [4:0] cv;
    logic [7:0] iv;
  } exp_t;

  exp_t q[$];

  ctrl_sequencer dut (
    .clk(clk), .rstn_inter(rstn_inter), .prog_mem_data(prog_mem_data),
    .zero_flag(zero_flag), .pc_inc(pc_inc), .cnt_load(cnt_load),
    .cnt_val(cnt_val), .load_en(load_en), .store_en(store_en),
    .R0_ce(R0_ce), .R1_ce(R1_ce), .R0_oe(R0_oe), .R1_oe(R1_oe),
    .alu_en(alu_en), .alu_op(alu_op), .imm_en(imm_en), .imm_val(imm_val),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Program counter model, reset externally together with the sequencer
  always_ff @(posedge clk or negedge rstn_inter) begin
    if (!rstn_inter)   pc <= '0;
    else if (cnt_load) pc <= cnt_val;
    else if (pc_inc)   pc <= pc + 5'd1;
  end

  assign prog_mem_data = mem[pc];
  assign zero_flag     = (pc == 5'd6);

  function automatic logic [9:0] sb_now();
    return {pc_inc, cnt_load, load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, alu_en, imm_en};
  endfunction

  function automatic logic [31:0] outs();
    return 32'({state_dbg, halted, sb_now(), alu_op, cnt_val, imm_val});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [9:0] sb, input logic [2:0] op,
                      input logic [4:0] cv, input logic [7:0] iv);
    exp_t e;
    e.st = st; e.sb = sb; e.op = op; e.cv = cv; e.iv = iv;
    q.push_back(e);
  endtask

  // Monitor: every EXEC/WB cycle is a DUT output event and consumes one expectation
  always @(negedge clk) begin
    if (rstn_inter === 1'b1) begin
      chk("no_pcinc_with_cntload", 32'(pc_inc & cnt_load), 32'd0);
      chk("oe_exclusive", 32'(R0_oe & R1_oe), 32'd0);
      if (store_en) chk("store_one_ce", 32'(R0_ce ^ R1_ce), 32'd1);
      if (state_dbg == 3'd2 || state_dbg == 3'd3) begin
        if (q.size() == 0) begin
          chk("unexpected_output", outs(), 32'd0);
        end else begin
          exp_t e;
          exp_t g;
          e = q.pop_front();
          g = {state_dbg, sb_now(), alu_op, cnt_val, imm_val};
          chk("scoreboard", 32'(g), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn_inter = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);

    // Run A: LDI/ST/ALU/LD/ST/JZ(not taken)/JZ(taken)/JMP 31/NOP wrap/LDI
    mem[0] = 8'hC5; mem[1] = 8'h40; mem[2] = 8'h60; mem[3] = 8'h21;
    mem[4] = 8'h41; mem[5] = 8'hBA; mem[6] = 8'hBA; mem[26] = 8'h9F;
    mem[31] = 8'h00;
    push(3'd2, PI | LE | IE, 3'd0, 5'h05, 8'h05);
    push(3'd2, PI | SE | C0, 3'd0, 5'h00, 8'h00);
    push(3'd2, AE | O1,      3'd0, 5'h00, 8'h00);
    push(3'd3, PI | LE | AE | O1, 3'd0, 5'h00, 8'h00);
    push(3'd2, PI | LE | O1, 3'd0, 5'h01, 8'h01);
    push(3'd2, PI | SE | C1, 3'd0, 5'h01, 8'h01);
    push(3'd2, PI,           3'd0, 5'h1A, 8'h1A);
    push(3'd2, CL,           3'd0, 5'h1A, 8'h1A);
    push(3'd2, CL,           3'd0, 5'h1F, 8'h1F);
    push(3'd2, PI,           3'd0, 5'h00, 8'h00);
    push(3'd2, PI | LE | IE, 3'd0, 5'h05, 8'h05);
    @(negedge clk);
    rstn_inter = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    chk("runA_state_fetch", 32'(state_dbg), 32'd0);
    chk("runA_pc_after_wrap", 32'(pc), 32'd1);
    chk("runA_queue_drained", 32'(q.size()), 32'd0);

    // Run B: reset in the middle of LD's EXEC, then LD and HALT from address 0
    rstn_inter = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
    mem[0] = 8'h20;
    @(negedge clk);
    rstn_inter = 1'b1;
    n = 0;
    @(posedge clk);
    #1;
    while (state_dbg !== 3'd2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ld_exec_reached", 32'(state_dbg), 32'd2);
    chk("ld_exec_strobes", 32'(sb_now()), 32'(PI | LE | O0));
    rstn_inter = 1'b0;
    #1;
    chk("midrun_reset_outputs", outs(), 32'd0);
    repeat (2) @(posedge clk);
    push(3'd2, PI | LE | O0, 3'd0, 5'h00, 8'h00);
    push(3'd2, 10'd0,        3'd0, 5'h00, 8'h00);
    @(negedge clk);
    rstn_inter = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("halt_entered", 32'({halted, state_dbg}), 32'({1'b1, 3'd4}));
    chk("runB_queue_drained", 32'(q.size()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem[pc] = 8'($urandom);
      @(posedge clk);
      #1;
      chk("halt_idle", outs(), 32'({3'd4, 1'b1, 10'd0, 3'd0, 5'd0, 8'd0}));
    end
    chk("halt_pc_frozen", 32'(pc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
